mat_result_drain: RTL and testbench

// - Output end of the matrix multiplier: reads a finished ROWS x COLS result matrix from the result buffer

---
 rtl/mat_result_drain_pkg.sv | 16 +
 rtl/mat_drain_skid.sv | 62 ++++++
 rtl/mat_result_drain.sv | 123 ++++++++++++
 tb/tb_mat_result_drain.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_result_drain_pkg.sv
// Shared types and constants for the matrix result drain path.
package mat_result_drain_pkg;

    localparam int MSB        = 32;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {DRN_IDLE, DRN_READ, DRN_FLUSH, DRN_DONE} drain_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SKID_CW = clog2_min1(SKID_DEPTH + 1);
    localparam int SKID_PW = clog2_min1(SKID_DEPTH);

endpackage

// File: rtl/mat_drain_skid.sv
// 2-entry {last, data} FIFO with fall-through: when empty, the pushed word is presented
// on the out side in the same cycle, so read data reaches the consumer with no extra stage.
module mat_drain_skid
    import mat_result_drain_pkg::*;
#(
    parameter int DW = MSB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [DW-1:0]      i_push_data,
    input  logic               i_push_last,
    output logic               o_out_valid,
    output logic [DW-1:0]      o_out_data,
    output logic               o_out_last,
    input  logic               i_out_ready,
    output logic [SKID_CW-1:0] o_count,
    output logic               o_full,
    output logic               o_empty
);

    logic [DW:0]          r_mem [SKID_DEPTH];
    logic [SKID_PW-1:0]   r_wr_ptr;
    logic [SKID_PW-1:0]   r_rd_ptr;
    logic [SKID_CW-1:0]   r_count;

    logic                 w_wr;
    logic                 w_rd;
    logic [DW:0]          w_sel;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == SKID_CW'(SKID_DEPTH));
    assign o_count     = r_count;
    assign o_out_valid = !o_empty || i_push;
    assign w_sel       = o_empty ? {i_push_last, i_push_data} : r_mem[r_rd_ptr];
    assign {o_out_last, o_out_data} = o_out_valid ? w_sel : '0;

    // A push that is consumed straight through the bypass never touches storage.
    assign w_wr = i_push && !(o_empty && i_out_ready);
    assign w_rd = !o_empty && i_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {i_push_last, i_push_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mat_result_drain.sv
// Drains a ROWS x COLS result matrix from a 1-cycle synchronous buffer onto a valid/ready stream.
// Define MAT_DRAIN_TRANSPOSE_EN to read column-major (transposed stream); default is row-major.
module mat_result_drain
    import mat_result_drain_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int AW   = clog2_min1(ROWS * COLS),
    parameter int DW   = MSB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    localparam int RW  = clog2_min1(ROWS);
    localparam int CLW = clog2_min1(COLS);
    localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);
    localparam logic [CLW-1:0] COL_MAX = CLW'(COLS - 1);

    drain_state_t       r_state, w_state_nxt;
    logic [RW-1:0]      r_row;
    logic [CLW-1:0]     r_col;
    logic               r_inflight;
    logic               r_inflight_last;

    logic [SKID_CW-1:0] w_skid_count;
    logic               w_skid_full;
    logic               w_skid_empty;
    logic [SKID_CW:0]   w_occ;
    logic               w_last_rd;
    logic               w_pop;

    assign w_last_rd = (r_row == ROW_MAX) && (r_col == COL_MAX);
    assign w_occ     = {1'b0, w_skid_count} + {{SKID_CW{1'b0}}, r_inflight};
    assign w_pop     = out_valid && out_ready;
    assign rd_addr   = AW'(r_row) * AW'(COLS) + AW'(r_col);

    mat_drain_skid #(.DW(DW)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (rd_data),
        .i_push_last (r_inflight_last),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .i_out_ready (out_ready),
        .o_count     (w_skid_count),
        .o_full      (w_skid_full),
        .o_empty     (w_skid_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        rd_en       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            DRN_IDLE:  if (start) w_state_nxt = DRN_READ;
            DRN_READ: begin
                busy = 1'b1;
                // Reads outstanding never exceed skid capacity, so stalled data always has a home.
                rd_en = (w_occ < (SKID_CW + 1)'(SKID_DEPTH)) && !w_skid_full;
                if (rd_en && w_last_rd) w_state_nxt = DRN_FLUSH;
            end
            DRN_FLUSH: begin
                busy = 1'b1;
                if ((w_pop && out_last) || (w_skid_empty && !r_inflight)) w_state_nxt = DRN_DONE;
            end
            DRN_DONE: begin
                done        = 1'b1;
                w_state_nxt = DRN_IDLE;
            end
            default:   w_state_nxt = DRN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= DRN_IDLE;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= rd_en;
            r_inflight_last <= rd_en && w_last_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == DRN_IDLE)) begin
            r_row <= '0;
            r_col <= '0;
        end else if (rd_en) begin
`ifdef MAT_DRAIN_TRANSPOSE_EN
            if (r_row == ROW_MAX) begin
                r_row <= '0;
                r_col <= (r_col == COL_MAX) ? '0 : r_col + 1'b1;
            end else begin
                r_row <= r_row + 1'b1;
            end
`else
            if (r_col == COL_MAX) begin
                r_col <= '0;
                r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mat_result_drain.sv
// Directed bench for mat_result_drain with ROWS=2, COLS=3 and buffer word[a] = 32'h100 + a.
module tb_mat_result_drain;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int N    = ROWS * COLS;
    localparam int AW   = 3;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, rd_en, out_valid, out_last;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, out_data;

    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    logic [32:0]   acc_q [$];
    logic [31:0]   exp_v [N];

    mat_result_drain #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Result buffer model: 1-cycle read, junk when not read so timing slips show up.
    always @(posedge clk) rd_data <= rd_en ? (32'h100 + 32'(rd_addr)) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) acc_q.push_back({out_last, out_data});
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    // Index of first stream element differing from the expected matrix order, -1 if identical.
    function automatic int stream_err();
        if (acc_q.size() != N) return N;
        for (int k = 0; k < N; k++)
            if (acc_q[k] !== {(k == N - 1) ? 1'b1 : 1'b0, exp_v[k]}) return k;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, out_valid, out_last} !== 5'b0 || rd_addr !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b valid=%b last=%b addr=%0d data=%h want all 0",
                     busy, done, rd_en, out_valid, out_last, rd_addr, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rd_en, out_valid} !== 3'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b rd_en=%b valid=%b want 000", busy, rd_en, out_valid);
        end
    endtask

    task automatic test_basic();
        int  base;
        logic exp_valid;
        acc_q.delete();
        base = done_cnt;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 1) begin
                checks++;
                if (rd_en !== 1'b1 || rd_addr !== 3'd0) begin
                    failures++;
                    $display("FAIL basic_first_read got rd_en=%b addr=%0d want 1/0", rd_en, rd_addr);
                end
            end
            exp_valid = (i >= 2 && i <= 7);
            checks++;
            if (out_valid !== exp_valid) begin
                failures++;
                $display("FAIL basic_valid cyc=%0d got %b want %b", i, out_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== exp_v[i-2] || out_last !== (i == 7)) begin
                    failures++;
                    $display("FAIL basic_data cyc=%0d got %h/%b want %h/%b", i, out_data, out_last, exp_v[i-2], (i == 7));
                end
            end
            checks++;
            if (done !== (i == 8) || busy !== (i <= 7)) begin
                failures++;
                $display("FAIL basic_ctrl cyc=%0d got done=%b busy=%b want %b/%b", i, done, busy, (i == 8), (i <= 7));
            end
            @(negedge clk);
        end
        checks++;
        if (stream_err() != -1 || done_cnt - base != 1) begin
            failures++;
            $display("FAIL basic_stream got err_idx=%0d dones=%0d want -1/1", stream_err(), done_cnt - base);
        end
    endtask

    task automatic test_backpressure();
        int          base, issued, accepted;
        logic        got_done, prev_hold, pl;
        logic [31:0] pd;
        acc_q.delete();
        base = done_cnt; issued = 0; accepted = 0;
        got_done = 1'b0; prev_hold = 1'b0; pl = 1'b0; pd = '0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 60 && !got_done; i++) begin
            out_ready = !(i >= 3 && i <= 8);
            if (rd_en) begin
                checks++;
                if (issued - accepted >= 2) begin
                    failures++;
                    $display("FAIL bp_outstanding cyc=%0d got %0d before read want <2", i, issued - accepted);
                end
                issued++;
            end
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    failures++;
                    $display("FAIL bp_hold cyc=%0d got %b/%h/%b want 1/%h/%b", i, out_valid, out_data, out_last, pd, pl);
                end
            end
            prev_hold = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (out_valid && out_ready) accepted++;
            if (done) got_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!got_done || stream_err() != -1 || done_cnt - base != 1) begin
            failures++;
            $display("FAIL bp_stream got done_seen=%b err_idx=%0d dones=%0d want 1/-1/1", got_done, stream_err(), done_cnt - base);
        end
    endtask

    task automatic test_random();
        int   base;
        logic got_done;
        for (int run = 0; run < 20; run++) begin
            acc_q.delete();
            base = done_cnt;
            got_done = 1'b0;
            start = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 200 && !got_done; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (done) got_done = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (!got_done || stream_err() != -1 || done_cnt - base != 1) begin
                failures++;
                $display("FAIL random_run%0d got done_seen=%b err_idx=%0d dones=%0d want 1/-1/1",
                         run, got_done, stream_err(), done_cnt - base);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int   base;
        logic got_done;
        acc_q.delete();
        base = done_cnt;
        got_done = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        for (int i = 1; i < 40 && !got_done; i++) begin
            start = (i >= 1 && i <= 7);
            if (done) begin
                got_done = 1'b1;
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (!got_done || busy !== 1'b0 || stream_err() != -1 || done_cnt - base != 1) begin
            failures++;
            $display("FAIL swb_first got done_seen=%b busy=%b err_idx=%0d dones=%0d want 1/0/-1/1",
                     got_done, busy, stream_err(), done_cnt - base);
        end
        acc_q.delete();
        base = done_cnt;
        got_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_en !== 1'b1) begin
            failures++;
            $display("FAIL swb_restart got busy=%b rd_en=%b want 1/1", busy, rd_en);
        end
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (done) got_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!got_done || stream_err() != -1 || done_cnt - base != 1) begin
            failures++;
            $display("FAIL swb_second got done_seen=%b err_idx=%0d dones=%0d want 1/-1/1", got_done, stream_err(), done_cnt - base);
        end
    endtask

    task automatic test_reset_mid_drain();
        int   base;
        logic got_done;
        acc_q.delete();
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && acc_q.size() < 3; i++) @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (acc_q.size() != 3 || {busy, done, rd_en, out_valid, out_last} !== 5'b0 || rd_addr !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got accepts=%0d busy=%b done=%b rd_en=%b valid=%b last=%b addr=%0d data=%h want 3 and all 0",
                     acc_q.size(), busy, done, rd_en, out_valid, out_last, rd_addr, out_data);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        base = done_cnt;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != base || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_done got dones=%0d valid=%b busy=%b want 0/0/0", done_cnt - base, out_valid, busy);
        end
        acc_q.delete();
        got_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (done) got_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!got_done || stream_err() != -1 || done_cnt - base != 1) begin
            failures++;
            $display("FAIL midrst_fresh got done_seen=%b err_idx=%0d dones=%0d want 1/-1/1", got_done, stream_err(), done_cnt - base);
        end
    endtask

    initial begin
`ifdef MAT_DRAIN_TRANSPOSE_EN
        exp_v = '{32'h100, 32'h103, 32'h101, 32'h104, 32'h102, 32'h105};
`else
        exp_v = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_start_while_busy();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
